module_bcd_display_ctrl: RTL and testbench

Sequential controller that takes an 8-bit binary value on a load strobe and converts it to three BCD digits. The conversion is an iterative double-dabble that runs for 8 cycles and ends in a one-cycle done pulse. The block then time-multiplexes the held result onto a 4-digit common-anode 7-segment display, with leading-zero blanking. It sits between the value producer (switches, counter or ALU result) and the board display pins.

---
 rtl/module_bcd_display_ctrl_pkg.sv | 42 ++++
 rtl/module_bcd_to_7seg.sv | 26 ++
 rtl/module_bcd_display_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_module_bcd_display_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/module_bcd_display_ctrl_pkg.sv
// Shared types and constants for the BCD conversion / 7-segment display controller.
package pkg_bcd_display;

    localparam int unsigned BIN_W     = 8;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned BCD_W     = 3 * NIB_W;
    localparam int unsigned SEG_W     = 7;
    localparam int unsigned AN_W      = 4;
    localparam int unsigned BIT_COUNT = 8;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK  = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_ZERO   = 7'b1000000;
    localparam logic [AN_W-1:0]  ANODOS_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIG_UNITS    = 2'd0;
    localparam digit_idx_t DIG_TENS     = 2'd1;
    localparam digit_idx_t DIG_HUNDREDS = 2'd2;

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [NIB_W-1:0] dabble_adj(input logic [NIB_W-1:0] nib);
        return (nib >= NIB_W'(5)) ? nib + NIB_W'(3) : nib;
    endfunction

    function automatic logic [AN_W-1:0] anode_sel(input digit_idx_t idx);
        case (idx)
            DIG_UNITS:    return 4'b1110;
            DIG_TENS:     return 4'b1101;
            DIG_HUNDREDS: return 4'b1011;
            default:      return ANODOS_OFF;
        endcase
    endfunction

endpackage

// File: rtl/module_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern ({g,f,e,d,c,b,a}).
module module_bcd_to_7seg
    import pkg_bcd_display::*;
(
    input  logic [NIB_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg_c = 7'b1000000;
            4'd1:    o_seg_c = 7'b1111001;
            4'd2:    o_seg_c = 7'b0100100;
            4'd3:    o_seg_c = 7'b0110000;
            4'd4:    o_seg_c = 7'b0011001;
            4'd5:    o_seg_c = 7'b0010010;
            4'd6:    o_seg_c = 7'b0000010;
            4'd7:    o_seg_c = 7'b1111000;
            4'd8:    o_seg_c = 7'b0000000;
            4'd9:    o_seg_c = 7'b0010000;
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/module_bcd_display_ctrl.sv
// Loads an 8-bit value, converts it to three BCD digits by double-dabble and
// scans the held result onto a common-anode display with leading-zero blanking.
module module_bcd_display_ctrl
    import pkg_bcd_display::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [BIN_W-1:0] VALOR,
    input  logic             CARGAR,
    output logic             LISTO,
    output logic             HECHO,
    output logic [NIB_W-1:0] UNIDADES,
    output logic [NIB_W-1:0] DECENAS,
    output logic [NIB_W-1:0] CENTENAS,
    output logic [AN_W-1:0]  ANODOS,
    output logic [SEG_W-1:0] SEGMENTOS
);

    localparam int unsigned REF_W = $clog2(DIGIT_CYCLES);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_listo;
    logic                     r_hecho;
    logic                     w_listo_d;
    logic                     w_hecho_d;

    logic [BIN_W-1:0]         r_shift;
    logic [BCD_W-1:0]         r_scratch;
    logic [BIT_CNT_W-1:0]     r_bit_cnt;
    logic [NIB_W-1:0]         r_unidades;
    logic [NIB_W-1:0]         r_decenas;
    logic [NIB_W-1:0]         r_centenas;

    logic                     w_load;
    logic                     w_last_shift;
    logic [BCD_W-1:0]         w_scratch_adj;
    logic [BCD_W+BIN_W-1:0]   w_shifted;
    logic [BCD_W-1:0]         w_scratch_next;

    logic [REF_W-1:0]         r_refresh;
    digit_idx_t               r_digit_idx;
    digit_idx_t               w_idx_next;
    logic                     w_wrap;
    logic [NIB_W-1:0]         w_digit_mux;
    logic                     w_blank;
    logic [SEG_W-1:0]         w_seg_c;
    logic [AN_W-1:0]          r_anodos;
    logic [SEG_W-1:0]         r_seg;

    assign w_load        = CARGAR && r_listo;
    assign w_last_shift  = (r_state == SHIFT) && (r_bit_cnt == BIT_CNT_W'(BIT_COUNT - 1));
    assign w_scratch_adj = {dabble_adj(r_scratch[11:8]),
                            dabble_adj(r_scratch[7:4]),
                            dabble_adj(r_scratch[3:0])};
    assign w_shifted      = {w_scratch_adj, r_shift} << 1;
    assign w_scratch_next = w_shifted[BCD_W+BIN_W-1:BIN_W];

    // LISTO/HECHO are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_listo <= 1'b1;
            r_hecho <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_listo <= w_listo_d;
            r_hecho <= w_hecho_d;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_next = SHIFT;
            SHIFT:   if (w_last_shift) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_listo_d = 1'b0;
        w_hecho_d = 1'b0;
        case (w_state_next)
            IDLE:    w_listo_d = 1'b1;
            DONE:    w_hecho_d = 1'b1;
            default: ;
        endcase
    end

    // Result digits are written together with entry into DONE so they are valid with HECHO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift    <= '0;
            r_scratch  <= '0;
            r_bit_cnt  <= '0;
            r_unidades <= '0;
            r_decenas  <= '0;
            r_centenas <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_shift   <= VALOR;
                        r_scratch <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_shift   <= w_shifted[BIN_W-1:0];
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    if (w_last_shift) begin
                        r_centenas <= w_scratch_next[11:8];
                        r_decenas  <= w_scratch_next[7:4];
                        r_unidades <= w_scratch_next[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_wrap = (r_refresh == REF_W'(DIGIT_CYCLES - 1));

    // Selects the digit for the slot about to start, and whether it is a leading zero.
    always_comb begin
        w_idx_next  = DIG_UNITS;
        w_digit_mux = r_unidades;
        w_blank     = 1'b0;
        case (r_digit_idx)
            DIG_UNITS: w_idx_next = DIG_TENS;
            DIG_TENS:  w_idx_next = DIG_HUNDREDS;
            default:   w_idx_next = DIG_UNITS;
        endcase
        case (w_idx_next)
            DIG_TENS: begin
                w_digit_mux = r_decenas;
                w_blank     = (r_centenas == '0) && (r_decenas == '0);
            end
            DIG_HUNDREDS: begin
                w_digit_mux = r_centenas;
                w_blank     = (r_centenas == '0);
            end
            default: ;
        endcase
    end

    module_bcd_to_7seg u_bcd_to_7seg (
        .i_bcd   (w_digit_mux),
        .o_seg_c (w_seg_c)
    );

    // Display pins only change at slot boundaries; a slot is never corrected mid-way.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_refresh   <= '0;
            r_digit_idx <= DIG_UNITS;
            r_anodos    <= anode_sel(DIG_UNITS);
            r_seg       <= SEG_ZERO;
        end else if (w_wrap) begin
            r_refresh   <= '0;
            r_digit_idx <= w_idx_next;
            r_anodos    <= w_blank ? ANODOS_OFF : anode_sel(w_idx_next);
            r_seg       <= w_blank ? SEG_BLANK : w_seg_c;
        end else begin
            r_refresh   <= r_refresh + REF_W'(1);
        end
    end

    assign LISTO     = r_listo;
    assign HECHO     = r_hecho;
    assign UNIDADES  = r_unidades;
    assign DECENAS   = r_decenas;
    assign CENTENAS  = r_centenas;
    assign ANODOS    = r_anodos;
    assign SEGMENTOS = r_seg;

endmodule

// File: tb/tb_module_bcd_display_ctrl.sv
// Self-checking bench: decimal-arithmetic reference model for conversion, timing and display scan.
module tb_module_bcd_display_ctrl;

    localparam int unsigned DC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] valor;
    logic       cargar;
    logic       listo;
    logic       hecho;
    logic [3:0] unidades;
    logic [3:0] decenas;
    logic [3:0] centenas;
    logic [3:0] anodos;
    logic [6:0] segmentos;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc   = 0;
    logic [11:0] m_bcd   = '0;

    module_bcd_display_ctrl #(.DIGIT_CYCLES(DC)) dut (
        .CLK       (clk),
        .RST       (rst),
        .VALOR     (valor),
        .CARGAR    (cargar),
        .LISTO     (listo),
        .HECHO     (hecho),
        .UNIDADES  (unidades),
        .DECENAS   (decenas),
        .CENTENAS  (centenas),
        .ANODOS    (anodos),
        .SEGMENTOS (segmentos)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; gives the scan phase.
    always @(posedge clk) begin
        if (rst) n_cyc <= 0;
        else     n_cyc <= n_cyc + 1;
    end

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {ANODOS, SEGMENTOS} for scan phase n with held digits b.
    function automatic logic [10:0] ref_disp(input int n, input logic [11:0] b);
        int   slot;
        int   hund;
        int   tens;
        int   units;
        int   dig;
        logic blank;
        slot  = (n / DC) % 3;
        hund  = int'(b[11:8]);
        tens  = int'(b[7:4]);
        units = int'(b[3:0]);
        blank = (slot == 2) ? (hund == 0) : (slot == 1) ? (hund == 0 && tens == 0) : 1'b0;
        dig   = (slot == 2) ? hund : (slot == 1) ? tens : units;
        if (blank) return {4'b1111, 7'b1111111};
        return {4'(~(4'b0001 << slot)), ref_seg(dig)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; cargar = 1'b0; valor = 8'd0;
        repeat (3) @(negedge clk);
        n_tests++; if (listo !== 1'b1) begin n_fail++; $display("FAIL reset_listo: got %b expected 1", listo); end
        n_tests++; if (hecho !== 1'b0) begin n_fail++; $display("FAIL reset_hecho: got %b expected 0", hecho); end
        n_tests++; if ({centenas, decenas, unidades} !== 12'h000) begin n_fail++; $display("FAIL reset_digits: got %h expected 000", {centenas, decenas, unidades}); end
        n_tests++; if (anodos !== 4'b1110) begin n_fail++; $display("FAIL reset_anodos: got %b expected 1110", anodos); end
        n_tests++; if (segmentos !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg: got %b expected 1000000", segmentos); end
        rst = 1'b0;
        m_bcd = '0;
    endtask

    task automatic test_latency(input int v);
        logic [11:0] old_bcd;
        logic [11:0] new_bcd;
        logic [11:0] exp_bcd;
        old_bcd = m_bcd;
        new_bcd = ref_bcd(v);
        valor = 8'(v); cargar = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) cargar = 1'b0;
            exp_bcd = (j >= 8) ? new_bcd : old_bcd;
            n_tests++; if (listo !== (j == 9)) begin n_fail++; $display("FAIL latency_listo v=%0d j=%0d: got %b expected %b", v, j, listo, (j == 9)); end
            n_tests++; if (hecho !== (j == 8)) begin n_fail++; $display("FAIL latency_hecho v=%0d j=%0d: got %b expected %b", v, j, hecho, (j == 8)); end
            n_tests++; if ({centenas, decenas, unidades} !== exp_bcd) begin n_fail++; $display("FAIL latency_digits v=%0d j=%0d: got %h expected %h", v, j, {centenas, decenas, unidades}, exp_bcd); end
        end
        m_bcd = new_bcd;
    endtask

    task automatic test_back_to_back(input int a, input int b);
        valor = 8'(a); cargar = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 2) valor = 8'(b);
            n_tests++; if (hecho !== (j == 8 || j == 18)) begin n_fail++; $display("FAIL b2b_hecho a=%0d b=%0d j=%0d: got %b", a, b, j, hecho); end
            n_tests++; if (listo !== (j == 9 || j == 19)) begin n_fail++; $display("FAIL b2b_listo a=%0d b=%0d j=%0d: got %b", a, b, j, listo); end
            if (j == 8) begin
                n_tests++; if ({centenas, decenas, unidades} !== ref_bcd(a)) begin n_fail++; $display("FAIL b2b_first got %h expected %h", {centenas, decenas, unidades}, ref_bcd(a)); end
            end
            if (j == 18) begin
                n_tests++; if ({centenas, decenas, unidades} !== ref_bcd(b)) begin n_fail++; $display("FAIL b2b_second got %h expected %h", {centenas, decenas, unidades}, ref_bcd(b)); end
            end
        end
        cargar = 1'b0;
        m_bcd = ref_bcd(b);
    endtask

    task automatic test_ignore_busy(input int a, input int b);
        valor = 8'(a); cargar = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 0) cargar = 1'b0;
            n_tests++; if (hecho !== (j == 8)) begin n_fail++; $display("FAIL busy_hecho j=%0d: got %b expected %b", j, hecho, (j == 8)); end
            if (j == 8) begin
                n_tests++; if ({centenas, decenas, unidades} !== ref_bcd(a)) begin n_fail++; $display("FAIL busy_digits got %h expected %h", {centenas, decenas, unidades}, ref_bcd(a)); end
            end
            if (j == 3) begin valor = 8'(b); cargar = 1'b1; end
            if (j == 4) cargar = 1'b0;
        end
        m_bcd = ref_bcd(a);
    endtask

    task automatic test_random(input int n);
        int v;
        int jh;
        int edge_vals[7] = '{0, 9, 10, 99, 100, 199, 255};
        for (int k = 0; k < n; k++) begin
            v  = (k < 7) ? edge_vals[k] : int'($urandom_range(0, 255));
            jh = -1;
            valor = 8'(v); cargar = 1'b1;
            for (int j = 0; j < 12; j++) begin
                @(negedge clk);
                if (j == 0) cargar = 1'b0;
                if (hecho === 1'b1 && jh < 0) jh = j;
            end
            n_tests++; if (jh != 8) begin n_fail++; $display("FAIL random_hecho_cycle v=%0d: got %0d expected 8", v, jh); end
            n_tests++; if ({centenas, decenas, unidades} !== ref_bcd(v)) begin n_fail++; $display("FAIL random_digits v=%0d: got %h expected %h", v, {centenas, decenas, unidades}, ref_bcd(v)); end
            m_bcd = ref_bcd(v);
        end
    endtask

    task automatic test_scan(input int v);
        logic [11:0] bcd;
        logic [10:0] exp_d;
        bcd = ref_bcd(v);
        valor = 8'(v); cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        repeat (9 + 3 * DC + 1) @(negedge clk);
        for (int k = 0; k < 9 * int'(DC); k++) begin
            @(negedge clk);
            exp_d = ref_disp(n_cyc, bcd);
            n_tests++;
            if ({anodos, segmentos} !== exp_d) begin
                n_fail++;
                $display("FAIL scan v=%0d n=%0d: got an=%b seg=%b expected an=%b seg=%b", v, n_cyc, anodos, segmentos, exp_d[10:7], exp_d[6:0]);
            end
        end
        m_bcd = bcd;
    endtask

    task automatic test_reset_mid(input int v);
        logic hseen;
        hseen = 1'b0;
        valor = 8'(v); cargar = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) cargar = 1'b0;
            if (hecho === 1'b1) hseen = 1'b1;
        end
        rst = 1'b1; cargar = 1'b1; valor = 8'($urandom_range(1, 255));
        repeat (2) @(negedge clk);
        rst = 1'b0; cargar = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (hecho === 1'b1) hseen = 1'b1;
            n_tests++; if (listo !== 1'b1) begin n_fail++; $display("FAIL rstmid_listo k=%0d: got %b expected 1", k, listo); end
            if (k == 0) begin
                n_tests++; if ({centenas, decenas, unidades} !== 12'h000) begin n_fail++; $display("FAIL rstmid_digits got %h expected 000", {centenas, decenas, unidades}); end
                n_tests++; if (anodos !== 4'b1110) begin n_fail++; $display("FAIL rstmid_anodos got %b expected 1110", anodos); end
                n_tests++; if (segmentos !== 7'b1000000) begin n_fail++; $display("FAIL rstmid_seg got %b expected 1000000", segmentos); end
            end
        end
        n_tests++; if (hseen !== 1'b0) begin n_fail++; $display("FAIL rstmid_hecho: got %b expected 0", hseen); end
        m_bcd = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency(153);
        test_scan(153);
        test_back_to_back(255, 0);
        test_scan(0);
        test_scan(15);
        test_ignore_busy(42, 200);
        test_random(20);
        test_scan(100);
        test_scan(7);
        test_scan(int'($urandom_range(0, 255)));
        test_latency(98);
        test_reset_mid(231);
        test_latency(64);
        test_scan(255);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
